// File: rtl/dlx_mem_bus_ctrl.sv
// Bus controller between the DLX MMU and an SRAM-style external bus.
// It holds one access at a time. The address strobe stays up until the memory acks
// or the wait counter runs out. The core is stalled with busy, and completion is
// signalled with a single-cycle done pulse. On a timeout, bus_err is pulsed with done.
module dlx_mem_bus_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       phys_addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              bus_err,
  output logic              mem_as,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_dout,
  input  logic [31:0]       mem_din,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic [7:0]  cnt_next;
  logic [8:0]  cnt_inc;
  logic        timeout_hit;

  // The MMU drives a full 32-bit word, but only the low ADDR_W bits reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^phys_addr[31:ADDR_W];

  // The wait counter saturates at 8'hFF, and the timeout test uses the pre-saturated
  // increment. This lets "reaches TIMEOUT" fire on the edge that ends WAIT cycle TIMEOUT.
  assign cnt_inc     = {1'b0, cnt_reg} + 9'd1;
  assign cnt_next    = (cnt_reg == 8'hFF) ? cnt_reg : cnt_inc[7:0];
  assign timeout_hit = (cnt_inc >= 9'(TIMEOUT));

  // Access sequencer: every output is a register updated only here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      rdata     <= 32'd0;
      mem_as    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_dout  <= 32'd0;
    end else begin
      // done and bus_err are pulses: they are high only in the cycle spent in DONE.
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            mem_addr  <= phys_addr[ADDR_W-1:0];
            mem_wr    <= we;
            mem_dout  <= wdata;
            mem_as    <= 1'b1;
            busy      <= 1'b1;
            cnt_reg   <= 8'd0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            // An ack on the same edge as a timeout wins, so this branch comes first.
            if (!mem_wr) begin
              rdata <= mem_din;
            end
            mem_as    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (timeout_hit) begin
            cnt_reg   <= cnt_next;
            mem_as    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        DONE: begin
          // A request seen here is dropped on purpose. The core must re-present it in IDLE.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mem_bus_ctrl.sv
// Scoreboard bench for dlx_mem_bus_ctrl. Stimulus pushes the expected completion of each
// access into a queue. A monitor checks the bus phase and pops the queue on every done.
// A simple memory responder acks after a programmed number of WAIT cycles, where 0 = never.
module tb_dlx_mem_bus_ctrl;

  localparam int TIMEOUT = 4;
  localparam int ADDR_W  = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              we;
  logic [31:0]       phys_addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              bus_err;
  logic              mem_as;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_dout;
  logic [31:0]       mem_din;
  logic              mem_ack;

  dlx_mem_bus_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .phys_addr(phys_addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .bus_err(bus_err),
    .mem_as(mem_as), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [23:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = 0;
  logic [31:0] resp_data = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: it acks in WAIT cycle number ack_delay, counting from 1.
  initial begin
    int k;
    k = 0;
    mem_ack = 1'b0;
    mem_din = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_as) begin
        k++;
        if (ack_delay != 0 && k == ack_delay) begin
          mem_ack = 1'b1;
          mem_din = resp_data;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        k = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // Monitor: it checks the bus phase against the queue head and pops the head on done.
  initial begin
    int   cyc;
    int   accept_cyc;
    logic prev_busy;
    exp_t e;
    cyc = 0;
    accept_cyc = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        cyc++;
        if (busy && !prev_busy) begin
          check("access_expected", 32'(exp_q.size() != 0), 32'd1);
          accept_cyc = cyc;
        end
        if (mem_as && exp_q.size() != 0) begin
          e = exp_q[0];
          check("mem_addr", 32'(mem_addr), 32'(e.a));
          check("mem_wr", 32'(mem_wr), 32'(e.w));
          check("mem_dout", mem_dout, e.wd);
          check("busy_in_wait", 32'(busy), 32'd1);
        end
        if (done) begin
          check("done_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("bus_err", 32'(bus_err), 32'(e.err));
            check("rdata", rdata, e.rd);
            check("latency", 32'(cyc - accept_cyc), 32'(e.lat));
            check("busy_at_done", 32'(busy), 32'd0);
            check("mem_as_at_done", 32'(mem_as), 32'd0);
            $display("txn: we=%0d addr=%h err=%0d rdata=%h lat=%0d",
                     e.w, e.a, bus_err, rdata, cyc - accept_cyc);
          end
        end
        prev_busy = busy;
      end
    end
  end

  task automatic expect_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic err, input logic [31:0] rd, input int lat);
    exp_t e;
    e.w = w; e.a = a[23:0]; e.wd = wd; e.err = err; e.rd = rd; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_within_bound", 32'(done), 32'd1);
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; we = w; phys_addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input int dly, input logic [31:0] din,
                           input logic err, input logic [31:0] rd, input int lat);
    ack_delay = dly;
    resp_data = din;
    expect_txn(w, a, wd, err, rd, lat);
    start_req(w, a, wd);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b0; req = 1'b0; we = 1'b0; phys_addr = 32'd0; wdata = 32'd0;
    #1 reset = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_mem_as", 32'(mem_as), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dout", mem_dout, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: read, ack in the first WAIT cycle.
    do_access(1'b0, 32'hAB12_3456, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1);
    // 2: write with 3 wait states (ack in WAIT cycle 4). rdata keeps the previous read.
    do_access(1'b1, 32'h0000_0100, 32'h1234_5678, 4, 32'hFFFF_0000, 1'b0, 32'hDEAD_BEEF, 4);
    // 3: timeout with no ack. rdata is unchanged.
    do_access(1'b0, 32'h0000_0200, 32'h0, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, TIMEOUT);
    // 4: ack on the timeout edge wins.
    do_access(1'b0, 32'h00C0_FFEE, 32'h0, TIMEOUT, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, TIMEOUT);

    // 5a: req held high gives two accesses separated by one IDLE cycle.
    ack_delay = 2;
    resp_data = 32'h1111_2222;
    expect_txn(1'b0, 32'h0055_AA00, 32'h0, 1'b0, 32'h1111_2222, 2);
    expect_txn(1'b0, 32'h0055_AA00, 32'h0, 1'b0, 32'h1111_2222, 2);
    @(negedge clk);
    req = 1'b1; we = 1'b0; phys_addr = 32'h0055_AA00; wdata = 32'h0;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    req = 1'b0;
    check("b2b_done_count", 32'(n), 32'd2);
    repeat (3) @(negedge clk);

    // 5b: req pulses during WAIT and DONE must not start another access.
    ack_delay = 3;
    resp_data = 32'h3333_4444;
    expect_txn(1'b0, 32'h0000_0300, 32'h0, 1'b0, 32'h3333_4444, 3);
    start_req(1'b0, 32'h0000_0300, 32'h0);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);

    // 6: reset mid-WAIT abandons the access at once, without a clock edge.
    ack_delay = 0;
    expect_txn(1'b1, 32'h0000_0400, 32'h5555_6666, 1'b0, 32'h0, 0);
    start_req(1'b1, 32'h0000_0400, 32'h5555_6666);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_mem_as", 32'(mem_as), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    do_access(1'b0, 32'h0000_0500, 32'h0, 2, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 2);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
